// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (i_*) and data (d_*) ports.
// Latency: ready pulses 2 cycles after a request is seen in IDLE when mem_ack comes in the first BUSY cycle; 3-cycle min turnaround.
// Backpressure: requesters hold req until their one-cycle ready pulse; mem_req is held until mem_ack; one transaction outstanding.
// Ports: clk, rst (async active-low) | i_req/i_addr -> i_rdata/i_ready (fetch) |
//        d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready (load/store) |
//        mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ack (memory) | grant_d (status)
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          grant_d
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int             CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          data_win;

  // Data has priority unless fetch has already been passed over STARVE_MAX times in a row.
  assign data_win = d_req && (!i_req || (starve_cnt < STARVE_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_d    <= 1'b0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state   <= BUSY;
            mem_req <= 1'b1;
            grant_d <= data_win;
            if (data_win) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // Only data grants that bypass a waiting fetch count towards starvation.
              if (i_req) begin
                if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
              end else begin
                starve_cnt <= '0;
              end
            end else begin
              mem_we     <= 1'b0;
              mem_addr   <= i_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (grant_d) begin
              d_ready <= 1'b1;
              // A store leaves the previous load result visible.
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          // Ready is a single-cycle pulse; requesters update req before IDLE samples it.
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter with a scoreboard.
// Drivers issue requests from command queues; a memory responder acks with a chosen delay;
// a monitor predicts each grant with a priority/starvation reference model and checks responses.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          grant_d;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
    int            cyc;
  } txn_t;

  typedef struct {
    logic          is_d;
    logic          we;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic s_i = 1'b0;
  logic s_d = 1'b0;
  txn_t f_cmd_q[$];
  txn_t d_cmd_q[$];
  txn_t f_pend_q[$];
  txn_t d_pend_q[$];
  exp_t sb_q[$];
  int   dly_q[$];
  logic grant_log[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int   fixed_delay = 0;
  bit   spurious = 1'b0;
  bit   lat_chk = 1'b0;
  bit   f_busy = 1'b0;
  bit   d_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string detail);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, detail);
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.gap = gap; t.cyc = 0;
    return t;
  endfunction

  // Grant history packed MSB-first: 1 = data, 0 = fetch.
  function automatic int log_pattern();
    int v = 0;
    foreach (grant_log[k]) v = v * 2 + int'(grant_log[k]);
    return v;
  endfunction

  // Request lines as the arbiter saw them on the latest rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    s_i <= i_req;
    s_d <= d_req;
  end

  initial begin : fetch_drv
    int   idle;
    txn_t c;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (f_busy) i_req = 1'b0;
        f_busy = 1'b0;
        idle = 0;
      end else begin
        if (f_busy && i_ready) begin
          f_busy = 1'b0; i_req = 1'b0; idle = 0;
        end
        if (!f_busy && f_cmd_q.size() > 0) begin
          if (idle >= f_cmd_q[0].gap) begin
            c = f_cmd_q.pop_front();
            c.cyc = cyc;
            i_req = 1'b1; i_addr = c.addr;
            f_pend_q.push_back(c);
            f_busy = 1'b1;
          end else idle++;
        end
      end
    end
  end

  initial begin : data_drv
    int   idle;
    txn_t c;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (d_busy) d_req = 1'b0;
        d_busy = 1'b0;
        idle = 0;
      end else begin
        if (d_busy && d_ready) begin
          d_busy = 1'b0; d_req = 1'b0; idle = 0;
        end
        if (!d_busy && d_cmd_q.size() > 0) begin
          if (idle >= d_cmd_q[0].gap) begin
            c = d_cmd_q.pop_front();
            c.cyc = cyc;
            d_req = 1'b1; d_we = c.we; d_addr = c.addr; d_wdata = c.wdata;
            d_pend_q.push_back(c);
            d_busy = 1'b1;
          end else idle++;
        end
      end
    end
  end

  initial begin : responder
    int wait_cnt;
    bit active;
    wait_cnt = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) active = 1'b0;
      else begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (!active) begin
            active = 1'b1;
            wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            dly_q.push_back(wait_cnt);
          end
          if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            active = 1'b0;
            if (mem_we) begin
              ref_mem[mem_addr] = mem_wdata;
              mem_rdata = $urandom;
            end else mem_rdata = rd(mem_addr);
          end else wait_cnt--;
        end else if (spurious && ($urandom_range(0, 3) == 0)) begin
          mem_ack = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    bit            prev_req;
    bit            dwin;
    int            hold;
    int            streak;
    txn_t          t;
    exp_t          e;
    logic [AW-1:0] cur_addr;
    logic          cur_we;
    logic [DW-1:0] last_dload;
    prev_req = 1'b0; hold = 0; streak = 0; cur_addr = '0; cur_we = 1'b0; last_dload = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0; hold = 0; streak = 0; last_dload = '0;
        sb_q.delete(); dly_q.delete(); f_pend_q.delete(); d_pend_q.delete();
      end else begin
        if (mem_req && !prev_req) begin
          chk("grant_has_request", {63'd0, s_i | s_d}, 64'd1);
          // Data first, unless fetch has already waited through SM data grants.
          dwin = s_d && (!s_i || streak < SM);
          streak = (dwin && s_i) ? ((streak < SM) ? streak + 1 : SM) : 0;
          grant_log.push_back(grant_d);
          chk("grant_d", {63'd0, grant_d}, {63'd0, dwin});
          if (dwin ? (d_pend_q.size() == 0) : (f_pend_q.size() == 0))
            fail_now("grant_pending", "granted port has no outstanding request");
          else begin
            t = dwin ? d_pend_q.pop_front() : f_pend_q.pop_front();
            cur_addr = t.addr;
            cur_we = dwin && t.we;
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, t.addr});
            chk("mem_we", {63'd0, mem_we}, {63'd0, cur_we});
            if (cur_we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, t.wdata});
            e.is_d = dwin; e.we = cur_we; e.rdata = rd(t.addr); e.cyc = t.cyc;
            sb_q.push_back(e);
          end
          hold = 1;
        end else if (mem_req) begin
          hold++;
          chk("mem_addr_hold", {32'd0, mem_addr}, {32'd0, cur_addr});
          chk("mem_we_hold", {63'd0, mem_we}, {63'd0, cur_we});
        end else if (prev_req) begin
          if (dly_q.size() == 0) fail_now("mem_req_cycles", "mem_req fell with no ack delay recorded");
          else chk("mem_req_cycles", 64'(hold), 64'(dly_q.pop_front() + 1));
        end
        prev_req = mem_req;

        if (i_ready || d_ready) begin
          if (sb_q.size() == 0) fail_now("unexpected_ready", "ready pulse with no transaction in flight, required none");
          else begin
            e = sb_q.pop_front();
            chk("ready_port", {62'd0, i_ready, d_ready}, {62'd0, !e.is_d, e.is_d});
            if (e.is_d) begin
              if (e.we) chk("d_rdata_store_keep", {32'd0, d_rdata}, {32'd0, last_dload});
              else begin
                chk("d_rdata", {32'd0, d_rdata}, {32'd0, e.rdata});
                last_dload = e.rdata;
              end
            end else chk("i_rdata", {32'd0, i_rdata}, {32'd0, e.rdata});
            if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(2 + fixed_delay));
          end
        end
      end
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (n < budget && !(f_cmd_q.size() == 0 && d_cmd_q.size() == 0 && !f_busy && !d_busy
                           && sb_q.size() == 0 && !mem_req)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now({"timeout_", nm}, "transactions still outstanding after cycle budget");
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ctl"}, {59'd0, i_ready, d_ready, mem_req, mem_we, grant_d}, 64'd0);
    chk({nm, "_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({nm, "_data"}, {32'd0, i_rdata | d_rdata | mem_wdata}, 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int exp_pat;
    ref_mem[32'h0]  = 32'h20080005;
    ref_mem[32'h20] = 32'h00001234;

    // Reset held with random inputs: every output stays 0.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
      d_we = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
      #1;
      chk_outputs_zero("reset_outputs");
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    rst = 1'b1;

    // First fetch at address 0, ack in the first BUSY cycle.
    @(posedge clk);
    fixed_delay = 0; lat_chk = 1'b1;
    f_cmd_q.push_back(mk(1'b0, 32'h0, 32'h0, 0));
    wait_idle("fetch0", 50);
    lat_chk = 1'b0;
    chk("fetch0_i_rdata", {32'd0, i_rdata}, {32'd0, 32'h20080005});

    // Simultaneous fetch and load: data first, fetch next.
    grant_log.delete();
    @(posedge clk);
    d_cmd_q.push_back(mk(1'b0, 32'h100, 32'h0, 0));
    f_cmd_q.push_back(mk(1'b0, 32'h4, 32'h0, 0));
    wait_idle("simultaneous", 50);
    chk("simul_grant_count", 64'(grant_log.size()), 64'd2);
    chk("simul_grant_order", 64'(log_pattern()), 64'b10);

    // Load 0x1234 into d_rdata, then a store must leave it untouched.
    @(posedge clk);
    d_cmd_q.push_back(mk(1'b0, 32'h20, 32'h0, 0));
    d_cmd_q.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 1));
    wait_idle("store", 50);
    chk("store_keeps_d_rdata", {32'd0, d_rdata}, {32'd0, 32'h00001234});
    chk("store_mem_write", {32'd0, rd(32'h10)}, {32'd0, 32'hDEADBEEF});
    @(posedge clk);
    d_cmd_q.push_back(mk(1'b0, 32'h10, 32'h0, 0));
    wait_idle("store_readback", 50);
    chk("store_readback", {32'd0, d_rdata}, {32'd0, 32'hDEADBEEF});

    // Continuous data and fetch demand: 4 data grants, then 1 fetch, repeating.
    grant_log.delete();
    @(posedge clk);
    for (int k = 0; k < 10; k++) d_cmd_q.push_back(mk(1'b0, 32'h200 + 32'(4 * k), 32'h0, 0));
    for (int k = 0; k < 2; k++) f_cmd_q.push_back(mk(1'b0, 32'h40 + 32'(4 * k), 32'h0, 0));
    wait_idle("starve", 200);
    exp_pat = 0;
    for (int g = 0; g < 12; g++) exp_pat = exp_pat * 2 + ((g == 4 || g == 9) ? 0 : 1);
    chk("starve_grant_count", 64'(grant_log.size()), 64'd12);
    chk("starve_grant_order", 64'(log_pattern()), 64'(exp_pat));

    // Slow memory: ack after 5 extra cycles.
    @(posedge clk);
    fixed_delay = 5; lat_chk = 1'b1;
    d_cmd_q.push_back(mk(1'b0, 32'h300, 32'h0, 0));
    wait_idle("slow_ack", 60);
    lat_chk = 1'b0; fixed_delay = 0;

    // Reset in the middle of a data grant that bypassed a waiting fetch.
    fixed_delay = 20;
    @(posedge clk);
    d_cmd_q.push_back(mk(1'b0, 32'h400, 32'h0, 0));
    f_cmd_q.push_back(mk(1'b0, 32'h8, 32'h0, 0));
    n = 0;
    while (n < 20 && !mem_req) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("reset_busy_grant", "no grant seen before mid-transaction reset");
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk_outputs_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    fixed_delay = 0;
    grant_log.delete();
    rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) d_cmd_q.push_back(mk(1'b0, 32'h500 + 32'(4 * k), 32'h0, 0));
    f_cmd_q.push_back(mk(1'b0, 32'hC, 32'h0, 0));
    wait_idle("after_reset", 100);
    chk("after_reset_grant_count", 64'(grant_log.size()), 64'd6);
    chk("after_reset_grant_order", 64'(log_pattern()), 64'b111101);

    // Random mix with random ack delays and stray acks while not busy.
    spurious = 1'b1; fixed_delay = -1;
    @(posedge clk);
    for (int k = 0; k < 40; k++)
      f_cmd_q.push_back(mk(1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0, int'($urandom_range(0, 3))));
    for (int k = 0; k < 60; k++)
      d_cmd_q.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                           int'($urandom_range(0, 3))));
    wait_idle("random", 5000);
    spurious = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sits between the pipeline core and the memory inside top.
- Data accesses have priority. A starvation guard guarantees forward progress for fetch.
- The ready pulses double as the pipeline's stall-release signals.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, max consecutive data grants while fetch waits (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
i_req  in  1  fetch request, held until i_ready
i_addr  in  AW  fetch address
i_rdata  out  DW  fetched word, valid while i_ready=1
i_ready  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid while d_ready=1
d_ready  out  1  one-cycle data completion pulse
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one or more cycles after mem_req rises
grant_d  out  1  1 while the current/last grant is the data port (status)

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0, the FSM goes to IDLE, and starve_cnt goes to 0.
  - Any in-flight memory transaction is abandoned; mem_req falls immediately without waiting for a clock.
- FSM states are IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If neither request is asserted, remain in IDLE.
  - Otherwise choose a winner:
    - Data wins if d_req && (!i_req || starve_cnt < STARVE_MAX).
    - Else fetch wins.
  - On the next edge:
    - Latch the winner's addr, we and wdata onto the mem_* outputs (fetch forces mem_we=0).
    - Set mem_req=1, set grant_d, and go to BUSY.
- starve_cnt update at each grant:
  - Data grant with i_req=1: increment, saturating at STARVE_MAX.
  - Fetch grant, or data grant with i_req=0: clear to 0.
- BUSY:
  - mem_* outputs are held stable.
  - On the edge where mem_ack=1:
    - mem_req goes to 0.
    - The granted port's ready goes to 1.
    - If the transaction is a read, mem_rdata is captured into that port's rdata. On a store, d_rdata keeps its previous value.
    - Go to RESP.
- RESP:
  - The ready pulse lasts exactly one cycle, then the FSM returns to IDLE.
  - Requesters sample ready and deassert or change req by the following edge, so IDLE never re-grants a completed request.
- Latency: with mem_ack on the first cycle mem_req is high, a request completes with ready high 2 cycles after the request is seen in IDLE. Minimum turnaround is 3 cycles per transaction.
- mem_ack outside BUSY is ignored.
- Only one transaction is outstanding at a time; no pipelining of requests.
- Both requests arriving on the same cycle: resolved by the priority rule above. The loser stays pending and is granted at the next IDLE.
- A requester dropping req mid-transaction is a protocol violation. The transaction still completes and ready still pulses.
- Address and data are never modified; there is no width conversion.

Test Plan:
- Hold rst=0 for 3 cycles with random inputs → all outputs 0. Assert i_req with i_addr=0x00000000 after release, ack after 1 cycle with mem_rdata=0x20080005 → mem_addr=0x0 with mem_we=0, then i_ready=1 for one cycle with i_rdata=0x20080005.
- Assert i_req and d_req (load, d_addr=0x100) together → data is granted first (mem_addr=0x100, grant_d=1), d_ready pulses, then fetch is granted on the next IDLE.
- Store d_addr=0x10, d_wdata=0xDEADBEEF with d_rdata previously 0x1234 → mem_we=1, mem_wdata=0xDEADBEEF, d_ready pulses, d_rdata stays 0x1234.
- Hold d_req continuously with i_req held, STARVE_MAX=4 → exactly 4 data grants, then 1 fetch grant, then the data/fetch pattern repeats.
- Delay mem_ack by 5 cycles → mem_req and mem_addr stay stable for 6 cycles and no ready pulse occurs before the ack. Assert rst low during BUSY → mem_req falls immediately and the FSM restarts in IDLE with starve_cnt=0.
